// File: rtl/compare_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : compare_seq_if
//  Description : Operand/result handshake bundle for the sequential
//                magnitude comparator. The master drives operands and
//                consumes results; the slave is the comparator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface compare_seq_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             signed_i;
   logic             valid_o;
   logic             ready_i;
   logic             equal_o;
   logic             alarger_o;
   logic             blarger_o;

   modport master (
      output valid_i, a_i, b_i, signed_i, ready_i,
      input  ready_o, valid_o, equal_o, alarger_o, blarger_o
   );

   modport slave (
      input  valid_i, a_i, b_i, signed_i, ready_i,
      output ready_o, valid_o, equal_o, alarger_o, blarger_o
   );
endinterface
`default_nettype wire

// File: rtl/compare_seq.sv
`default_nettype none
// ============================================================================
//  Module      : compare_seq
//  Description : Multi-cycle magnitude comparator. Scans CHUNK bits per
//                cycle from the most significant chunk downwards and stops
//                at the first differing chunk. Signed mode flips both MSBs
//                at latch time so the scan is always an unsigned compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   compare_seq_if.slave bus
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
   localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             valid;
   logic             equal;
   logic             a_larger;
   logic             b_larger;

   logic [CHUNK-1:0] cur_a;
   logic [CHUNK-1:0] cur_b;
   logic             accept;
   logic             chunk_differs;
   logic             last_chunk;
   logic             release_result;

   assign accept         = bus.valid_i && (state == IDLE);
   assign chunk_differs  = (cur_a != cur_b);
   assign last_chunk     = (idx == '0);
   assign release_result = valid && bus.ready_i;

   // Select the chunk pair addressed by the scan index; an explicit compare
   // per chunk keeps the mux free of out-of-range selects for any NUM_CHUNKS.
   always_comb begin
      cur_a = '0;
      cur_b = '0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_a = op_a[i*CHUNK +: CHUNK];
            cur_b = op_b[i*CHUNK +: CHUNK];
         end
      end
   end

   // Next-state decode: accept in IDLE, stop scanning on a difference or
   // after the last chunk, leave DONE on the result handshake.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = SCAN;
         SCAN: if (chunk_differs || last_chunk) next_state = DONE;
         DONE: if (release_result) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Operand capture and scan index; the index only moves while scanning
   // continues, so it never leaves 0..NUM_CHUNKS-1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx  <= LAST_IDX;
         op_a <= '0;
         op_b <= '0;
      end else if (accept) begin
         idx  <= LAST_IDX;
         op_a <= bus.a_i ^ (bus.signed_i ? SIGN_MASK : '0);
         op_b <= bus.b_i ^ (bus.signed_i ? SIGN_MASK : '0);
      end else if ((state == SCAN) && !chunk_differs && !last_chunk) begin
         idx <= idx - IDX_W'(1);
      end
   end

   // Result registers: written once when the scan resolves, then held
   // until the next scan resolves.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid    <= 1'b0;
         equal    <= 1'b0;
         a_larger <= 1'b0;
         b_larger <= 1'b0;
      end else begin
         valid <= (next_state == DONE);
         if (state == SCAN) begin
            if (chunk_differs) begin
               equal    <= 1'b0;
               a_larger <= (cur_a > cur_b);
               b_larger <= (cur_a < cur_b);
            end else if (last_chunk) begin
               equal    <= 1'b1;
               a_larger <= 1'b0;
               b_larger <= 1'b0;
            end
         end
      end
   end

   assign bus.ready_o   = (state == IDLE);
   assign bus.valid_o   = valid;
   assign bus.equal_o   = equal;
   assign bus.alarger_o = a_larger;
   assign bus.blarger_o = b_larger;

endmodule
`default_nettype wire

// File: tb/tb_compare_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_seq
//  Description : Self-checking bench for compare_seq in three configurations
//                (32/4, 32/32, 16/8) against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int compared   = 0;
   int mismatched = 0;

   int cfg_w [3] = '{32, 32, 16};
   int cfg_c [3] = '{4, 32, 8};

   // Free-running clock, 10 time units.
   always #5 clk = ~clk;

   compare_seq_if #(.WIDTH(32)) bus0 ();
   compare_seq_if #(.WIDTH(32)) bus1 ();
   compare_seq_if #(.WIDTH(16)) bus2 ();

   compare_seq #(.WIDTH(32), .CHUNK(4))  dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
   compare_seq #(.WIDTH(32), .CHUNK(32)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
   compare_seq #(.WIDTH(16), .CHUNK(8))  dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int cfg, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
      case (cfg)
         0: begin bus0.valid_i = v; bus0.a_i = a; bus0.b_i = b; bus0.signed_i = s; end
         1: begin bus1.valid_i = v; bus1.a_i = a; bus1.b_i = b; bus1.signed_i = s; end
         default: begin
            bus2.valid_i = v; bus2.a_i = a[15:0]; bus2.b_i = b[15:0]; bus2.signed_i = s;
         end
      endcase
   endtask

   task automatic set_ready(input int cfg, input logic r);
      case (cfg)
         0: bus0.ready_i = r;
         1: bus1.ready_i = r;
         default: bus2.ready_i = r;
      endcase
   endtask

   task automatic get_out(input int cfg, output logic rdy, output logic vld,
                          output logic eq, output logic ag, output logic bg);
      case (cfg)
         0: begin rdy = bus0.ready_o; vld = bus0.valid_o; eq = bus0.equal_o;
                  ag = bus0.alarger_o; bg = bus0.blarger_o; end
         1: begin rdy = bus1.ready_o; vld = bus1.valid_o; eq = bus1.equal_o;
                  ag = bus1.alarger_o; bg = bus1.blarger_o; end
         default: begin rdy = bus2.ready_o; vld = bus2.valid_o; eq = bus2.equal_o;
                  ag = bus2.alarger_o; bg = bus2.blarger_o; end
      endcase
   endtask

   // Reference: compare the operands as integers; latency is the number of
   // chunks from the top down to (and including) the highest differing bit.
   function automatic void model(input int cfg, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, output logic eq, output logic ag,
                                 output logic bg, output int k);
      int          w;
      int          c;
      longint      mask;
      longint      av;
      longint      bv;
      logic [31:0] diff;
      int          h;
      w    = cfg_w[cfg];
      c    = cfg_c[cfg];
      mask = (longint'(1) << w) - 1;
      av   = longint'(a) & mask;
      bv   = longint'(b) & mask;
      if (s && av[w-1]) av = av - (longint'(1) << w);
      if (s && bv[w-1]) bv = bv - (longint'(1) << w);
      eq   = (av == bv);
      ag   = (av > bv);
      bg   = (av < bv);
      diff = 32'((longint'(a) ^ longint'(b)) & mask);
      if (diff == '0) begin
         k = w / c;
      end else begin
         h = 0;
         for (int i = 0; i < w; i++) if (diff[i]) h = i;
         k = (w - 1 - h) / c + 1;
      end
   endfunction

   // One full transaction with `hold` cycles of result backpressure during
   // which the input side is scrambled.
   task automatic run_txn(input int cfg, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold, input string tag);
      logic eq_e, ag_e, bg_e;
      int   k_e;
      int   k;
      logic rdy, vld, eq, ag, bg;
      model(cfg, a, b, s, eq_e, ag_e, bg_e, k_e);
      @(negedge clk);
      set_in(cfg, 1'b1, a, b, s);
      get_out(cfg, rdy, vld, eq, ag, bg);
      chk({tag, " ready_o idle"}, 64'(rdy), 64'(1));
      @(posedge clk);
      #1;
      set_in(cfg, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      k   = 0;
      vld = 1'b0;
      while (!vld && (k < cfg_w[cfg] / cfg_c[cfg] + 4)) begin
         @(posedge clk);
         #1;
         k++;
         get_out(cfg, rdy, vld, eq, ag, bg);
      end
      chk({tag, " latency"}, 64'(k), 64'(k_e));
      chk({tag, " valid_o"}, 64'(vld), 64'(1));
      chk({tag, " equal_o"}, 64'(eq), 64'(eq_e));
      chk({tag, " alarger_o"}, 64'(ag), 64'(ag_e));
      chk({tag, " blarger_o"}, 64'(bg), 64'(bg_e));
      chk({tag, " ready_o done"}, 64'(rdy), 64'(0));
      for (int i = 0; i < hold; i++) begin
         set_in(cfg, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
         @(posedge clk);
         #1;
         get_out(cfg, rdy, vld, eq, ag, bg);
         chk({tag, " hold valid_o"}, 64'(vld), 64'(1));
         chk({tag, " hold ready_o"}, 64'(rdy), 64'(0));
         chk({tag, " hold result"}, 64'({eq, ag, bg}), 64'({eq_e, ag_e, bg_e}));
      end
      set_in(cfg, 1'b0, $urandom, $urandom, 1'b0);
      set_ready(cfg, 1'b1);
      @(posedge clk);
      #1;
      get_out(cfg, rdy, vld, eq, ag, bg);
      chk({tag, " post valid_o"}, 64'(vld), 64'(0));
      chk({tag, " post ready_o"}, 64'(rdy), 64'(1));
      chk({tag, " retained"}, 64'({eq, ag, bg}), 64'({eq_e, ag_e, bg_e}));
      set_ready(cfg, 1'b0);
   endtask

   initial begin
      logic        rdy, vld, eq, ag, bg;
      logic [31:0] ra;
      logic [31:0] rb;

      for (int c = 0; c < 3; c++) begin
         set_in(c, 1'b0, '0, '0, 1'b0);
         set_ready(c, 1'b0);
      end

      // Reset state.
      #12;
      get_out(0, rdy, vld, eq, ag, bg);
      chk("rst ready_o", 64'(rdy), 64'(1));
      chk("rst valid_o", 64'(vld), 64'(0));
      chk("rst results", 64'({eq, ag, bg}), 64'(0));
      get_out(2, rdy, vld, eq, ag, bg);
      chk("rst16 ready_o", 64'(rdy), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed scenarios in every configuration.
      for (int c = 0; c < 3; c++) begin
         run_txn(c, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, $sformatf("c%0d unsigned", c));
         run_txn(c, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, $sformatf("c%0d signed", c));
         run_txn(c, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, $sformatf("c%0d neg1", c));
         run_txn(c, 32'h1234_5678, 32'h1234_5678, 1'b0, 0, $sformatf("c%0d equal", c));
         run_txn(c, 32'h00F0_0000, 32'h00E0_0000, 1'b0, 0, $sformatf("c%0d late3", c));
         run_txn(c, 32'h0000_0001, 32'h0000_0002, 1'b0, 0, $sformatf("c%0d lsb", c));
      end

      // Output backpressure with input churn.
      run_txn(0, 32'hDEAD_BEEF, 32'hDEAD_0000, 1'b0, 5, "backpressure");

      // Reset in the middle of a scan (during the chunk-4 cycle).
      run_txn(0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0, "pre reset");
      @(negedge clk);
      set_in(0, 1'b1, 32'h1111_1111, 32'h1111_1111, 1'b0);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      get_out(0, rdy, vld, eq, ag, bg);
      chk("midrst valid_o", 64'(vld), 64'(0));
      chk("midrst results", 64'({eq, ag, bg}), 64'(0));
      chk("midrst ready_o", 64'(rdy), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(0, 32'd5, 32'd5, 1'b0, 0, "after reset");

      // Randomized operands, biased towards equal and near-equal pairs.
      for (int c = 0; c < 3; c++) begin
         for (int n = 0; n < 500; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
               0:       rb = ra;
               1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
               default: rb = $urandom;
            endcase
            run_txn(c, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    $sformatf("c%0d rnd%0d", c, n));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
